boot_loader_ctrl: RTL
=====================

// Module: boot_loader_ctrl
// PURPOSE
// - Parametrised boot-image loader. Consumes the byte stream from a UART receiver and writes
//   DW-bit words into the instruction memory (write port, AW-bit word address).
// - Holds the core in reset until a framed image arrives with a valid checksum.
// - Frame: MAGIC, 16-bit word count N (LSB first), N words (BYTES=DW/8 bytes each, LSB first),
//   XOR checksum byte. Successor to the fixed 32-bit unframed ICCM programmer; adds framing,
//   checksum, overflow/timeout errors and re-load.
// PARAMETERS
// - AW          12     word-address width of target memory
// - DW          32     data word width; multiple of 8, 8..64
// - MAGIC       8'hA5  frame sync byte
// - TimeoutCyc  100000 max idle clk_i cycles between bytes inside a frame (>=2)
// - HoldAtReset 1'b1   1: core_hold_o=1 out of reset; 0: core runs until a MAGIC arrives
// PORTS
// - clk_i        in   1   clock
// - rst_ni       in   1   asynchronous active-low reset
// - rx_dv_i      in   1   one-cycle strobe, rx_byte_i valid
// - rx_byte_i    in   8   received byte
// - we_o         out  1   one-cycle memory write strobe
// - addr_o       out  AW  word address for write
// - wdata_o      out  DW  write data
// - core_hold_o  out  1   1 = keep core/system in reset
// - done_o       out  1   last frame loaded with good checksum (sticky until next MAGIC)
// - err_o        out  1   last frame failed (sticky until next MAGIC)
// BEHAVIOUR
// - One clock; reset is asynchronous and active-low.
// - Reset values: we_o=0, addr_o=0, wdata_o=0, done_o=0, err_o=0, core_hold_o=HoldAtReset,
//   state=IDLE, checksum=0, timer=0.
// - FSM: IDLE -> LEN_LO -> LEN_HI -> DATA -> CSUM -> DONE; on any error -> IDLE with err_o=1.
//   - IDLE: bytes other than MAGIC are ignored.
//     MAGIC -> LEN_LO; clear done_o/err_o, word ptr and checksum; core_hold_o=1 next cycle.
//   - LEN_LO/LEN_HI: assemble N.
//     N==0 or N>2**AW -> error (flagged the cycle after the LEN_HI byte).
//   - DATA: shift bytes LSB-first into wdata; checksum ^= byte.
//     On byte BYTES of a word: next cycle we_o=1 for exactly one cycle, with addr_o=word ptr and
//     wdata_o=assembled word. Word ptr then increments (AW-bit, no wrap since N<=2**AW).
//     After word N -> CSUM.
//   - CSUM: received byte == checksum -> DONE, done_o=1, core_hold_o=0 the cycle after the byte.
//     Mismatch -> IDLE, err_o=1, core_hold_o stays 1.
//   - DONE: behaves as IDLE (MAGIC starts a reload and re-asserts core_hold_o).
// - Timeout: timer counts clk_i cycles since the last rx_dv_i while in LEN_LO..CSUM.
//   At TimeoutCyc -> IDLE, err_o=1. Words already written are not undone.
// - Errors never release core_hold_o. With HoldAtReset=0, core_hold_o stays 0 until the first
//   MAGIC.
// - Checksum covers payload bytes only (not MAGIC, not length).
// - rx_dv_i is a single-cycle strobe at most once per 2 cycles; one byte consumed per strobe.
// - Async reset mid-frame: immediate return to reset values; a partial word is never written.
// - Latency: last byte strobe to we_o = 1 cycle; checksum byte to done_o/core_hold_o = 1 cycle.
// TESTING
// - Reset, HoldAtReset=1, no bytes -> core_hold_o=1, we_o never asserted.
// - DW=32: A5 02 00 | 13 00 00 00 | 37 01 00 00 | csum 25
//   -> we_o@addr0=0x00000013, we_o@addr1=0x00000137; done_o=1, core_hold_o=0.
// - Same frame with csum 26 -> both writes occur, err_o=1, done_o=0, core_hold_o=1;
//   then a resend of the good frame -> done_o=1, err_o=0.
// - AW=4: A5 11 00 (N=17 > 16) -> err_o=1 after the length byte, no we_o.
// - TimeoutCyc=50: stop after 2 of 4 bytes of word 0 -> err_o=1 at cycle 50, no we_o.
//   Assert rst_ni low mid-word -> all outputs return to reset values.
// - DW=16, frame A5 01 00 34 12 26 -> we_o addr0=0x1234, done_o=1.
//   While in DONE, stray byte 0x00 -> ignored; then MAGIC -> core_hold_o=1, done_o=0.

Source files
------------

// File: rtl/boot_loader_ctrl.sv
// boot_loader_ctrl
//   Receives a framed boot image over a UART byte stream and writes it into the
//   instruction memory. The core is held in reset until a complete image with a
//   matching XOR checksum has been loaded.
//
//   Frame: MAGIC | N[7:0] | N[15:8] | N words (DW/8 bytes each, LSB first) | XOR of payload
//
// Ports
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   rx_dv_i      one-cycle strobe, rx_byte_i valid
//   rx_byte_i    received byte
//   we_o         one-cycle memory write strobe
//   addr_o       word address of the write
//   wdata_o      write data
//   core_hold_o  1 = keep the core in reset
//   done_o       last frame loaded with a good checksum (sticky until next MAGIC)
//   err_o        last frame failed (sticky until next MAGIC)

module boot_loader_ctrl #(
  parameter int unsigned AW          = 12,
  parameter int unsigned DW          = 32,
  parameter logic [7:0]  MAGIC       = 8'hA5,
  parameter int unsigned TimeoutCyc  = 100000,
  parameter logic        HoldAtReset = 1'b1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          rx_dv_i,
  input  logic [7:0]    rx_byte_i,
  output logic          we_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] wdata_o,
  output logic          core_hold_o,
  output logic          done_o,
  output logic          err_o
);

  localparam int unsigned BYTES = DW / 8;
  localparam int unsigned BcW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int unsigned TW    = $clog2(TimeoutCyc + 1);
  localparam logic [BcW-1:0] BcLast  = BcW'(BYTES - 1);
  localparam logic [TW-1:0]  TimLast = TW'(TimeoutCyc - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [7:0]     len_lo_q, len_lo_d;
  logic [15:0]    rem_q, rem_d;
  logic [AW-1:0]  ptr_q, ptr_d;
  logic [BcW-1:0] bcnt_q, bcnt_d;
  logic [DW-1:0]  shreg_q, shreg_d;
  logic [7:0]     csum_q, csum_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           we_q, we_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;
  logic           hold_q, hold_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  logic [15:0]    len_full;
  logic           len_bad;
  logic [DW-1:0]  word_asm;
  logic           active;

  assign len_full = {rx_byte_i, len_lo_q};
  assign len_bad  = (len_full == 16'd0) || (32'(len_full) > (32'd1 << AW));
  // Bytes enter at the top and shift down, so the first byte ends up in the LSBs.
  assign word_asm = (shreg_q >> 8) | (DW'(rx_byte_i) << (DW - 8));
  assign active   = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                    (state_q == S_DATA)   || (state_q == S_CSUM);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      len_lo_q <= '0;
      rem_q    <= '0;
      ptr_q    <= '0;
      bcnt_q   <= '0;
      shreg_q  <= '0;
      csum_q   <= '0;
      timer_q  <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      hold_q   <= HoldAtReset;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_lo_q <= len_lo_d;
      rem_q    <= rem_d;
      ptr_q    <= ptr_d;
      bcnt_q   <= bcnt_d;
      shreg_q  <= shreg_d;
      csum_q   <= csum_d;
      timer_q  <= timer_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      hold_q   <= hold_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_lo_d = len_lo_q;
    rem_d    = rem_q;
    ptr_d    = ptr_q;
    bcnt_d   = bcnt_q;
    shreg_d  = shreg_q;
    csum_d   = csum_q;
    timer_d  = '0;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    hold_d   = hold_q;
    done_d   = done_q;
    err_d    = err_q;

    if (active && !rx_dv_i) begin
      // Idle gap inside a frame: abort once TimeoutCyc cycles pass without a byte.
      if (timer_q == TimLast) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end else if (rx_dv_i) begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          if (rx_byte_i == MAGIC) begin
            state_d = S_LEN_LO;
            done_d  = 1'b0;
            err_d   = 1'b0;
            ptr_d   = '0;
            csum_d  = '0;
            bcnt_d  = '0;
            shreg_d = '0;
            hold_d  = 1'b1;
          end
        end
        S_LEN_LO: begin
          len_lo_d = rx_byte_i;
          state_d  = S_LEN_HI;
        end
        S_LEN_HI: begin
          if (len_bad) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end else begin
            rem_d   = len_full;
            state_d = S_DATA;
          end
        end
        S_DATA: begin
          csum_d = csum_q ^ rx_byte_i;
          if (bcnt_q == BcLast) begin
            we_d    = 1'b1;
            addr_d  = ptr_q;
            wdata_d = word_asm;
            ptr_d   = ptr_q + 1'b1;
            bcnt_d  = '0;
            shreg_d = '0;
            rem_d   = rem_q - 16'd1;
            if (rem_q == 16'd1) state_d = S_CSUM;
          end else begin
            bcnt_d  = bcnt_q + 1'b1;
            shreg_d = word_asm;
          end
        end
        S_CSUM: begin
          if (rx_byte_i == csum_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign we_o        = we_q;
  assign addr_o      = addr_q;
  assign wdata_o     = wdata_q;
  assign core_hold_o = hold_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule
